// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage.
// Owns the PC, issues word fetches over a req/gnt + rvalid handshake, buffers
// returned instructions with their PCs and presents the buffer head to IF/ID.
// Redirects and flushes mark in-flight responses stale so they are dropped.
// Optional feature macro: FETCH_PERF_CNT_EN (stall / discarded-response counters).
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_en,
  input  logic        if_id_pipeline_en,
  input  logic        if_id_pipeline_flush,
  input  logic        jump_branch_taken,
  input  logic [31:0] jump_branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        fetch_stall,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_discarded
);

  localparam int PW  = $clog2(BUF_DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0]  CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW1-1:0] DEPTH_W  = CW1'(BUF_DEPTH);
  localparam logic [PW-1:0]  PTR_ZERO = PW'(0);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   last_pc_q, last_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]   buf_pc_q    [BUF_DEPTH];
  logic [31:0]   buf_pc_d    [BUF_DEPTH];
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_instr_d [BUF_DEPTH];
  logic [31:0]   tag_q       [BUF_DEPTH];
  logic [31:0]   tag_d       [BUF_DEPTH];

  logic valid_s, issue_s, hs_s, rsp_s, rsp_drop_s, rsp_push_s, clear_s, pop_s;

  // Handshake qualifiers: issue credit, response routing, buffer pop.
  always_comb begin
    valid_s    = (occ_q != CNT_ZERO);
    // Occupancy plus outstanding never exceeds the buffer, so responses always fit.
    issue_s    = rst_n && pc_en && !jump_branch_taken &&
                 (({1'b0, occ_q} + {1'b0, out_q}) < DEPTH_W);
    hs_s       = issue_s && imem_gnt;
    // A response with nothing outstanding (e.g. one that straddled reset) is ignored.
    rsp_s      = imem_rvalid && (out_q != CNT_ZERO);
    clear_s    = jump_branch_taken || if_id_pipeline_flush;
    rsp_drop_s = rsp_s && ((disc_q != CNT_ZERO) || clear_s);
    rsp_push_s = rsp_s && !rsp_drop_s;
    pop_s      = valid_s && if_id_pipeline_en && !clear_s;
  end

  // Outputs to memory and IF/ID, driven straight from PC and buffer head.
  always_comb begin
    imem_req    = issue_s;
    imem_addr   = pc_q;
    if_valid    = valid_s;
    fetch_stall = !valid_s;
    if (valid_s) begin
      if_instr = buf_instr_q[rd_ptr_q];
      if_pc    = buf_pc_q[rd_ptr_q];
    end else begin
      if_instr = NOP_INSTR;
      if_pc    = last_pc_q;
    end
  end

  // Next PC, outstanding / stale counters and last-presented PC.
  always_comb begin
    if (jump_branch_taken) begin
      pc_d = jump_branch_target & 32'hFFFF_FFFC;
    end else if (hs_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end

    out_d = out_q;
    if (hs_s) begin
      out_d = out_d + CNT_ONE;
    end else begin
      out_d = out_d;
    end
    if (rsp_s) begin
      out_d = out_d - CNT_ONE;
    end else begin
      out_d = out_d;
    end

    // On redirect/flush every request already in flight becomes stale; the new
    // request of a flush-only cycle is not part of that set.
    if (clear_s) begin
      disc_d = rsp_s ? (out_q - CNT_ONE) : out_q;
    end else if (rsp_s && (disc_q != CNT_ZERO)) begin
      disc_d = disc_q - CNT_ONE;
    end else begin
      disc_d = disc_q;
    end

    if (pop_s) begin
      last_pc_d = buf_pc_q[rd_ptr_q];
    end else begin
      last_pc_d = last_pc_q;
    end
  end

  // Instruction buffer: push of tagged responses, pop towards IF/ID, clear.
  always_comb begin
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    occ_d       = occ_q;
    if (clear_s) begin
      rd_ptr_d = PTR_ZERO;
      wr_ptr_d = PTR_ZERO;
      occ_d    = CNT_ZERO;
    end else begin
      if (rsp_push_s) begin
        buf_pc_d[wr_ptr_q]    = tag_q[tag_rd_q];
        buf_instr_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({rsp_push_s, pop_s})
        2'b10:   occ_d = occ_q + CNT_ONE;
        2'b01:   occ_d = occ_q - CNT_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Tag FIFO: PC of each live (non-stale) outstanding request, in issue order.
  always_comb begin
    tag_d = tag_q;
    if (clear_s) begin
      tag_rd_d = PTR_ZERO;
      tag_wr_d = PTR_ZERO;
    end else if (rsp_push_s) begin
      tag_rd_d = tag_rd_q + PTR_ONE;
      tag_wr_d = tag_wr_q;
    end else begin
      tag_rd_d = tag_rd_q;
      tag_wr_d = tag_wr_q;
    end
    if (hs_s) begin
      tag_d[tag_wr_d] = pc_q;
      tag_wr_d        = tag_wr_d + PTR_ONE;
    end else begin
      tag_wr_d = tag_wr_d;
    end
  end

  // State registers; reset abandons all in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      last_pc_q <= RESET_PC;
      occ_q     <= CNT_ZERO;
      out_q     <= CNT_ZERO;
      disc_q    <= CNT_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      wr_ptr_q  <= PTR_ZERO;
      tag_rd_q  <= PTR_ZERO;
      tag_wr_q  <= PTR_ZERO;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc_q[i]    <= 32'h0000_0000;
        buf_instr_q[i] <= 32'h0000_0000;
        tag_q[i]       <= 32'h0000_0000;
      end
    end else begin
      pc_q        <= pc_d;
      last_pc_q   <= last_pc_d;
      occ_q       <= occ_d;
      out_q       <= out_d;
      disc_q      <= disc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      tag_rd_q    <= tag_rd_d;
      tag_wr_q    <= tag_wr_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
      tag_q       <= tag_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  // Saturating counters; redirects and flushes do not clear them.
  always_comb begin
    if (!valid_s && if_id_pipeline_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (rsp_drop_s && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
      drop_cnt_q  <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_discarded    = drop_cnt_q;
`else
  assign perf_stall_cycles = 32'h0000_0000;
  assign perf_discarded    = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with a memory model that
// returns the fetch address as data after a programmable latency, and a
// scoreboard of the PCs expected at the IF/ID interface.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, pc_en, if_id_pipeline_en, if_id_pipeline_flush, jump_branch_taken;
  logic [31:0] jump_branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_instr, if_pc, perf_stall_cycles, perf_discarded;
  logic        if_valid, fetch_stall;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_no = 0;
  int lat = 1;
  int pops = 0;
  int p0 = 0;
  int first_gnt_tick = -1;
  int first_valid_tick = -1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_en(pc_en),
    .if_id_pipeline_en(if_id_pipeline_en), .if_id_pipeline_flush(if_id_pipeline_flush),
    .jump_branch_taken(jump_branch_taken), .jump_branch_target(jump_branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .fetch_stall(fetch_stall),
    .perf_stall_cycles(perf_stall_cycles), .perf_discarded(perf_discarded)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, sample handshake and IF/ID output, advance.
  task automatic tick();
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr[0];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (first_gnt_tick >= 0 && first_valid_tick < 0 && if_valid) first_valid_tick = tick_no;
    if (imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      if (first_gnt_tick < 0) first_gnt_tick = tick_no;
    end
    if (imem_rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (rst_n && if_valid && if_id_pipeline_en && !if_id_pipeline_flush && !jump_branch_taken) begin
      if (sb.size() == 0) begin
        check("unexpected_output", if_pc, 32'hFFFF_FFFF);
      end else begin
        check("out_pc", if_pc, sb[0]);
        check("out_instr", if_instr, sb[0]);
        void'(sb.pop_front());
        pops++;
      end
    end
    @(posedge clk);
    cyc++;
    tick_no++;
    @(negedge clk);
  endtask

  task automatic load_sb(input logic [31:0] base);
    sb.delete();
    for (int i = 0; i < 48; i++) sb.push_back(base + 32'(i * 4));
  endtask

  initial begin
    rst_n = 1'b0; pc_en = 1'b1; if_id_pipeline_en = 1'b1; if_id_pipeline_flush = 1'b0;
    jump_branch_taken = 1'b0; jump_branch_target = 32'h0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instr, NOP);
    check("rst_pc", if_pc, 32'h0);
    check("rst_stall", 32'(fetch_stall), 32'd1);
    check("rst_perf_disc", perf_discarded, 32'd0);

    // Sequential fetch from RESET_PC with zero-wait memory
    load_sb(32'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    check("first_valid_latency", 32'(first_valid_tick - first_gnt_tick), 32'd2);
    check("seq_progress", 32'(pops >= 3), 32'd1);

    // IF/ID stalled: buffer fills and requests stop
    if_id_pipeline_en = 1'b0;
    repeat (5) tick();
    check("full_req_low", 32'(imem_req), 32'd0);
    check("full_valid", 32'(if_valid), 32'd1);
    if_id_pipeline_en = 1'b1;
    p0 = pops;
    repeat (8) tick();
    check("release_progress", 32'(pops > p0), 32'd1);

    // Redirect with two late outstanding responses
    pc_en = 1'b0;
    repeat (6) tick();
    check("drain1_valid", 32'(if_valid), 32'd0);
    lat = 3; pc_en = 1'b1;
    tick(); tick();
    check("two_out_req_low", 32'(imem_req), 32'd0);
    jump_branch_taken = 1'b1; jump_branch_target = 32'h0000_0103;
    tick();
    jump_branch_taken = 1'b0;
    load_sb(32'h0000_0100);
    p0 = pops;
    repeat (12) tick();
    check("redir1_progress", 32'(pops > p0), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_disc_redir1", perf_discarded, 32'd2);
`else
    check("perf_disc_redir1", perf_discarded, 32'd0);
`endif

    // Redirect coincident with a response, pc_en low
    pc_en = 1'b0;
    repeat (8) tick();
    check("drain2_valid", 32'(if_valid), 32'd0);
    lat = 1; pc_en = 1'b1;
    tick();
    pc_en = 1'b0; jump_branch_taken = 1'b1; jump_branch_target = 32'h0000_0200;
    #1 check("redir2_req_low", 32'(imem_req), 32'd0);
    tick();
    jump_branch_taken = 1'b0;
    repeat (3) tick();
    check("redir2_rv_dropped", 32'(if_valid), 32'd0);
    check("redir2_frozen_req", 32'(imem_req), 32'd0);
    load_sb(32'h0000_0200);
    pc_en = 1'b1;
    p0 = pops;
    repeat (10) tick();
    check("redir2_progress", 32'(pops > p0), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_disc_redir2", perf_discarded, 32'd3);
`else
    check("perf_disc_redir2", perf_discarded, 32'd0);
`endif

    // Flush with a full buffer: contents lost, PC continues sequentially
    if_id_pipeline_en = 1'b0;
    repeat (5) tick();
    check("flush_pre_full", 32'(imem_req), 32'd0);
    if_id_pipeline_flush = 1'b1;
    tick();
    if_id_pipeline_flush = 1'b0;
    check("flush_valid", 32'(if_valid), 32'd0);
    check("flush_instr", if_instr, NOP);
    check("flush_stall", 32'(fetch_stall), 32'd1);
    void'(sb.pop_front());
    void'(sb.pop_front());
    if_id_pipeline_en = 1'b1;
    p0 = pops;
    repeat (10) tick();
    check("flush_progress", 32'(pops > p0), 32'd1);

    // Reset with one request outstanding; late response afterwards is ignored
    pc_en = 1'b0;
    repeat (6) tick();
    lat = 6; pc_en = 1'b1;
    tick();
    pc_en = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("mid_rst_valid", 32'(if_valid), 32'd0);
    check("mid_rst_pc", if_pc, 32'h0);
    check("mid_rst_perf", perf_discarded, 32'd0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("late_rv_pending_gone", 32'(pend_addr.size()), 32'd0);
    check("late_rv_ignored", 32'(if_valid), 32'd0);
    load_sb(32'h0);
    lat = 1; pc_en = 1'b1;
    p0 = pops;
    repeat (10) tick();
    check("restart_progress", 32'(pops > p0), 32'd1);
`ifndef FETCH_PERF_CNT_EN
    check("perf_stall_off", perf_stall_cycles, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
